pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (F, D, X, M, W).
- Decides when the PC and the F/D and D/X latches hold, when bubbles are injected, and when wrong-path instructions are flushed.
- Launches and tracks multi-cycle mult/div operations on the shared multdiv unit in X, with a timeout guard.
- Sits beside the forwarding unit; consumes latch IRs, never operand data.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_md.sv | 74 +++++++
 rtl/pipe_hazard_ctrl.sv | 80 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, IR field positions and sequencer state encoding for the
// pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned ALUOP_LSB  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// Mult/div sequencer: launches an operation on the shared multdiv unit, waits
// for its result (or a timeout) and flags a one-cycle completion.
module md_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic start_mul,
  input  logic start_div,
  input  logic md_resultRDY,
  input  logic md_exception,
  output logic ctrl_MULT,
  output logic ctrl_DIV,
  output logic md_busy,
  output logic md_done,
  output logic md_exc
);

  md_state_t          state, next_state;
  logic [CNT_W-1:0]   count;
  logic               timeout;

  assign timeout = (count == CNT_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      md_exc <= 1'b0;
    end else begin
      state <= next_state;
      if (state == MD_BUSY) count <= count + CNT_W'(1);
      else                  count <= '0;
      // md_exc is only meaningful during MD_DONE; clearing it on exit keeps it 0 in IDLE
      if (state == MD_BUSY) begin
        if (md_resultRDY) md_exc <= md_exception;
        else if (timeout) md_exc <= 1'b1;
      end else if (state == MD_DONE) begin
        md_exc <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ctrl_MULT || ctrl_DIV)      next_state = MD_BUSY;
      MD_BUSY: if (md_resultRDY || timeout)    next_state = MD_DONE;
      MD_DONE:                                 next_state = IDLE;
      default:                                 next_state = IDLE;
    endcase
  end

  // Start pulses are suppressed while reset is held so outputs stay quiet in reset
  always_comb begin
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    case (state)
      IDLE: begin
        ctrl_MULT = ~reset & start_mul;
        ctrl_DIV  = ~reset & start_div & ~start_mul;
      end
      MD_BUSY: md_busy = 1'b1;
      MD_DONE: md_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes and multi-cycle mult/div stalls driven from the F/D and D/X IRs.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_taken,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        nop_dx,
  output logic        nop_xm,
  output logic        flush_fd,
  output logic        md_done,
  output logic        md_exc
);

  logic [4:0] fd_op, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       dx_mul, dx_div, dx_md, dx_lw, fd_sw;
  logic       md_busy, md_idle, md_start, br_flush, load_use;
  logic       unused_ir_bits;

  assign fd_op  = fd_ir[OPCODE_LSB +: 5];
  assign fd_rs  = fd_ir[RS_LSB +: 5];
  assign fd_rt  = fd_ir[RT_LSB +: 5];
  assign dx_op  = dx_ir[OPCODE_LSB +: 5];
  assign dx_rd  = dx_ir[RD_LSB +: 5];
  assign dx_alu = dx_ir[ALUOP_LSB +: 5];

  assign unused_ir_bits = ^{fd_ir[26:22], fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  assign dx_mul = (dx_op == OP_ALU) && (dx_alu == ALU_MUL);
  assign dx_div = (dx_op == OP_ALU) && (dx_alu == ALU_DIV);
  assign dx_md  = dx_mul | dx_div;
  assign dx_lw  = (dx_op == OP_LW);
  assign fd_sw  = (fd_op == OP_SW);

  md_seq #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clock        (clock),
    .reset        (reset),
    .start_mul    (dx_mul),
    .start_div    (dx_div),
    .md_resultRDY (md_resultRDY),
    .md_exception (md_exception),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_exc       (md_exc)
  );

  // Fixed priority in IDLE: mult/div start, then branch flush, then load-use
  assign md_idle  = ~md_busy & ~md_done & ~reset;
  assign md_start = ctrl_MULT | ctrl_DIV;
  assign br_flush = md_idle & ~dx_md & branch_taken;
  assign load_use = md_idle & ~dx_md & ~branch_taken & dx_lw & (dx_rd != '0)
                  & ((fd_rs == dx_rd) | ((fd_rt == dx_rd) & ~fd_sw));

  assign stall_pc = md_start | md_busy | load_use;
  assign stall_fd = md_start | md_busy | load_use;
  assign stall_dx = md_start | md_busy;
  assign nop_xm   = md_start | md_busy;
  assign nop_dx   = br_flush | load_use;
  assign flush_fd = br_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue-based scoreboard of
// expected output vectors.
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_ir, dx_ir;
  logic        branch_taken, md_resultRDY, md_exception;
  logic        ctrl_MULT, ctrl_DIV, stall_pc, stall_fd, stall_dx;
  logic        nop_dx, nop_xm, flush_fd, md_done, md_exc;

  pipe_hazard_ctrl #(
    .MD_TIMEOUT (40),
    .CNT_W      (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .fd_ir        (fd_ir),
    .dx_ir        (dx_ir),
    .branch_taken (branch_taken),
    .md_resultRDY (md_resultRDY),
    .md_exception (md_exception),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall_pc     (stall_pc),
    .stall_fd     (stall_fd),
    .stall_dx     (stall_dx),
    .nop_dx       (nop_dx),
    .nop_xm       (nop_xm),
    .flush_fd     (flush_fd),
    .md_done      (md_done),
    .md_exc       (md_exc)
  );

  always #5 clock = ~clock;

  // {ctrl_MULT, ctrl_DIV, stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd, md_done, md_exc}
  localparam logic [9:0] E_ZERO = 10'b00_000_0_0_0_0_0;
  localparam logic [9:0] E_MUL  = 10'b10_111_0_1_0_0_0;
  localparam logic [9:0] E_DIV  = 10'b01_111_0_1_0_0_0;
  localparam logic [9:0] E_BUSY = 10'b00_111_0_1_0_0_0;
  localparam logic [9:0] E_DONE = 10'b00_000_0_0_0_1_0;
  localparam logic [9:0] E_DONX = 10'b00_000_0_0_0_1_1;
  localparam logic [9:0] E_LU   = 10'b00_110_1_0_0_0_0;
  localparam logic [9:0] E_BR   = 10'b00_000_1_0_1_0_0;

  typedef struct {
    logic [9:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  int  total  = 0;
  int  passed = 0;
  int  failed = 0;

  logic [31:0] NOP, LW5, LW0, ADD5, ADD_RS5, ADD_RT5, ADD_RS0, SW_RD5, SW_RT5, MUL, DIV;

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                      input logic rdy, input logic exc, input logic rst,
                      input logic [9:0] exp, input string tag);
    sb_t        it;
    logic [9:0] obs;
    fd_ir        = fd;
    dx_ir        = dx;
    branch_taken = br;
    md_resultRDY = rdy;
    md_exception = exc;
    reset        = rst;
    sb.push_back('{exp, tag});
    @(negedge clock);
    it  = sb.pop_front();
    obs = {ctrl_MULT, ctrl_DIV, stall_pc, stall_fd, stall_dx, nop_dx, nop_xm,
           flush_fd, md_done, md_exc};
    total++;
    assert (obs === it.exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    NOP     = 32'h0;
    LW5     = mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);
    LW0     = mk(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);
    ADD5    = mk(5'b00000, 5'd5, 5'd1, 5'd2, 5'd0);
    ADD_RS5 = mk(5'b00000, 5'd3, 5'd5, 5'd2, 5'd0);
    ADD_RT5 = mk(5'b00000, 5'd3, 5'd2, 5'd5, 5'd0);
    ADD_RS0 = mk(5'b00000, 5'd3, 5'd0, 5'd2, 5'd0);
    SW_RD5  = mk(5'b00111, 5'd5, 5'd1, 5'd0, 5'd0);
    SW_RT5  = mk(5'b00111, 5'd2, 5'd1, 5'd5, 5'd0);
    MUL     = mk(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00110);
    DIV     = mk(5'b00000, 5'd6, 5'd1, 5'd2, 5'b00111);

    reset = 1'b1; fd_ir = '0; dx_ir = '0;
    branch_taken = 1'b0; md_resultRDY = 1'b0; md_exception = 1'b0;
    @(posedge clock);
    #1;

    step(NOP, NOP, 0, 0, 0, 1, E_ZERO, "reset_idle");
    step(NOP, MUL, 0, 0, 0, 1, E_ZERO, "reset_mul_in_dx");
    step(NOP, NOP, 0, 0, 0, 0, E_ZERO, "idle");

    // load-use
    step(ADD_RS5, LW5,  0, 0, 0, 0, E_LU,   "lu_rs");
    step(ADD_RS5, NOP,  0, 0, 0, 0, E_ZERO, "lu_release");
    step(ADD_RT5, LW5,  0, 0, 0, 0, E_LU,   "lu_rt");
    step(SW_RD5,  LW5,  0, 0, 0, 0, E_ZERO, "lu_sw_rd");
    step(SW_RT5,  LW5,  0, 0, 0, 0, E_ZERO, "lu_sw_rt");
    step(ADD_RS0, LW0,  0, 0, 0, 0, E_ZERO, "lu_rd0");
    step(ADD_RS5, ADD5, 0, 0, 0, 0, E_ZERO, "lu_not_lw");

    // branch flush
    step(NOP,     NOP, 1, 0, 0, 0, E_BR,   "branch");
    step(NOP,     NOP, 0, 0, 0, 0, E_ZERO, "branch_release");
    step(ADD_RS5, LW5, 1, 0, 0, 0, E_BR,   "branch_over_lu");

    // rdy in IDLE is ignored
    step(NOP, NOP, 0, 1, 1, 0, E_ZERO, "idle_rdy_ignored");
    step(NOP, NOP, 0, 0, 0, 0, E_ZERO, "idle_after_rdy");

    // mul: result on the 17th busy cycle
    step(NOP, MUL, 0, 0, 0, 0, E_MUL, "mul_start");
    for (int i = 1; i <= 16; i++) step(NOP, MUL, 0, 0, 0, 0, E_BUSY, "mul_busy");
    step(NOP, MUL, 0, 1, 0, 0, E_BUSY, "mul_rdy");
    step(NOP, MUL, 0, 0, 0, 0, E_DONE, "mul_done");

    // back-to-back div, divide by zero on the 33rd busy cycle
    step(NOP, DIV, 0, 0, 0, 0, E_DIV, "div_start");
    for (int i = 1; i <= 32; i++) step(NOP, DIV, 0, 0, 0, 0, E_BUSY, "div_busy");
    step(NOP, DIV, 0, 1, 1, 0, E_BUSY, "div_rdy_exc");
    step(NOP, DIV, 0, 0, 0, 0, E_DONX, "div_done_exc");
    step(NOP, NOP, 0, 0, 0, 0, E_ZERO, "div_idle");

    // timeout: md_done on the 41st cycle after the start pulse
    step(NOP, MUL, 0, 0, 0, 0, E_MUL, "to_start");
    for (int i = 1; i <= 40; i++) step(NOP, MUL, 0, 0, 0, 0, E_BUSY, "to_busy");
    step(NOP, MUL, 0, 1, 0, 0, E_DONX, "to_done");
    step(NOP, NOP, 0, 0, 0, 0, E_ZERO, "to_idle");

    // ready and timeout coincide: ready wins
    step(NOP, DIV, 0, 0, 0, 0, E_DIV, "tie_start");
    for (int i = 1; i <= 39; i++) step(NOP, DIV, 0, 0, 0, 0, E_BUSY, "tie_busy");
    step(NOP, DIV, 0, 1, 0, 0, E_BUSY, "tie_rdy");
    step(NOP, DIV, 0, 0, 0, 0, E_DONE, "tie_done");
    step(NOP, NOP, 0, 0, 0, 0, E_ZERO, "tie_idle");

    // reset in the 5th busy cycle
    step(NOP, MUL, 0, 0, 0, 0, E_MUL, "rst_start");
    for (int i = 1; i <= 4; i++) step(NOP, MUL, 0, 0, 0, 0, E_BUSY, "rst_busy");
    step(NOP, MUL, 0, 0, 0, 1, E_ZERO, "rst_mid_op");
    step(NOP, MUL, 0, 0, 0, 0, E_MUL,  "rst_restart");
    step(NOP, MUL, 0, 1, 0, 0, E_BUSY, "rst_rdy");
    step(NOP, MUL, 0, 0, 0, 0, E_DONE, "rst_done");
    step(NOP, NOP, 0, 0, 0, 0, E_ZERO, "final_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
